// File: rtl/fetch_pkg.sv
// Shared opcode constants, fetch-mux encodings and FSM state type for the fetch controller.
package fetch_pkg;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JR   = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b10010;
    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_RS     = 2'b10;
    localparam logic [1:0] SEL_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_BR_WAIT  = 2'b10,
        ST_HALT     = 2'b11
    } state_e;
endpackage

// File: rtl/fetch_br_timer.sv
// 3-bit clear/enable counter bounding how long fetch waits for a branch outcome.
module fetch_br_timer (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);
    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 3'd0;
        end else if (en) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == 3'd7);
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage control FSM: stalls, redirects and branch waits for the PC / IF-ID register.
// Optional HALT instruction support is enabled by defining FETCH_CTRL_HALT_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_opcode,
    input  logic       id_valid,
    input  logic       ex_branch_valid,
    input  logic       ex_branch_taken,
    input  logic       hazard_load_use,
    input  logic       imem_ready,
    output logic [1:0] NextInstrSel,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       halted,
    output logic       br_timeout
);
    state_e state_q, state_d;
    logic   br_timeout_q, br_timeout_d;
    logic   tmr_clr, tmr_en, tmr_term;

    fetch_br_timer u_br_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .terminal (tmr_term)
    );

    always_comb begin
        state_d      = state_q;
        br_timeout_d = br_timeout_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        NextInstrSel = SEL_PC4;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!imem_ready) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    state_d = ST_WAIT_MEM;
                end else if (hazard_load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_valid) begin
                    case (id_opcode)
                        OP_JMP: begin
                            NextInstrSel = SEL_JUMP;
                            ifid_flush   = 1'b1;
                        end
                        OP_JR: begin
                            NextInstrSel = SEL_RS;
                            ifid_flush   = 1'b1;
                        end
                        OP_BEQ, OP_BNE: begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                            tmr_clr    = 1'b1;
                            state_d    = ST_BR_WAIT;
                        end
`ifdef FETCH_CTRL_HALT_EN
                        OP_HALT: begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                            state_d    = ST_HALT;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_BR_WAIT: begin
                // IF/ID stays frozen even on resolution; the redirect lands next cycle.
                ifid_en = 1'b0;
                tmr_en  = 1'b1;
                if (ex_branch_valid) begin
                    NextInstrSel = ex_branch_taken ? SEL_BRANCH : SEL_PC4;
                    state_d      = ST_RUN;
                end else if (tmr_term) begin
                    br_timeout_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    pc_en = 1'b0;
                end
            end
            ST_HALT: begin
`ifdef FETCH_CTRL_HALT_EN
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
`else
                state_d = ST_RUN;
`endif
            end
            default: state_d = ST_RUN;
        endcase

        // Reset holds the pipeline frozen with a NOP in IF/ID regardless of state.
        if (!rst) begin
            NextInstrSel = SEL_PC4;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            br_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            br_timeout_q <= br_timeout_d;
        end
    end

    assign br_timeout = br_timeout_q;

`ifdef FETCH_CTRL_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues expected outputs, a monitor checks them.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [4:0] NOP = 5'b00000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_opcode = NOP;
    logic       id_valid = 1'b0;
    logic       ex_branch_valid = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       hazard_load_use = 1'b0;
    logic       imem_ready = 1'b1;
    logic [1:0] NextInstrSel;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, halted, br_timeout;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         failures = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_opcode       (id_opcode),
        .id_valid        (id_valid),
        .ex_branch_valid (ex_branch_valid),
        .ex_branch_taken (ex_branch_taken),
        .hazard_load_use (hazard_load_use),
        .imem_ready      (imem_ready),
        .NextInstrSel    (NextInstrSel),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .br_timeout      (br_timeout)
    );

    always #5 clk = ~clk;

    // Expected vector: {NextInstrSel, pc_en, ifid_en, ifid_flush, idex_bubble, halted, br_timeout}
    function automatic logic [7:0] e(input int s, input int p, input int i, input int f,
                                     input int b, input int h, input int t);
        logic [1:0] sv;
        sv = s[1:0];
        return {sv, p[0], i[0], f[0], b[0], h[0], t[0]};
    endfunction

    task automatic drive(input int r, input logic [4:0] op, input int iv, input int hz,
                         input int im, input int bv, input int bt,
                         input logic [7:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        rst             = (r != 0);
        id_opcode       = op;
        id_valid        = (iv != 0);
        hazard_load_use = (hz != 0);
        imem_ready      = (im != 0);
        ex_branch_valid = (bv != 0);
        ex_branch_taken = (bt != 0);
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [7:0] exp_v, act_v;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {NextInstrSel, pc_en, ifid_en, ifid_flush, idex_bubble, halted, br_timeout};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got %b required %b (sel,pc,ifid,flush,bubble,halted,brto)",
                             nm, act_v, exp_v);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] def_v, rst_v, stall_v, brdec_v;
        def_v   = e(0, 1, 1, 0, 0, 0, 0);
        rst_v   = e(0, 0, 0, 1, 0, 0, 0);
        stall_v = e(0, 0, 0, 0, 0, 0, 0);
        brdec_v = e(0, 0, 1, 1, 0, 0, 0);

        drive(0, NOP, 0, 0, 1, 0, 0, rst_v, "reset_state");
        drive(0, OP_JMP, 1, 1, 0, 1, 1, rst_v, "reset_ignores_inputs");
        for (int i = 0; i < 3; i++) drive(1, NOP, 0, 0, 1, 0, 0, def_v, "idle_run");
        drive(1, OP_JMP, 0, 0, 1, 0, 0, def_v, "jmp_without_valid");
        drive(1, OP_JMP, 1, 0, 1, 0, 0, e(1, 1, 1, 1, 0, 0, 0), "jmp");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "after_jmp");
        drive(1, OP_JR, 1, 0, 1, 0, 0, e(2, 1, 1, 1, 0, 0, 0), "jr");

        drive(1, OP_BEQ, 1, 0, 1, 0, 0, brdec_v, "beq_decode");
        drive(1, NOP, 0, 0, 1, 0, 0, stall_v, "beq_wait");
        drive(1, NOP, 0, 0, 1, 1, 1, e(3, 1, 0, 0, 0, 0, 0), "beq_taken");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "after_beq");

        drive(1, OP_BNE, 1, 0, 1, 0, 0, brdec_v, "bne_decode");
        drive(1, NOP, 0, 0, 1, 1, 0, e(0, 1, 0, 0, 0, 0, 0), "bne_not_taken");

        drive(1, OP_JR, 1, 1, 1, 0, 0, e(0, 0, 0, 0, 1, 0, 0), "hazard_with_jr");
        drive(1, OP_JR, 1, 0, 1, 0, 0, e(2, 1, 1, 1, 0, 0, 0), "jr_after_hazard");

        drive(1, OP_JMP, 1, 1, 0, 0, 0, stall_v, "imem_stall_priority");
        drive(1, NOP, 0, 0, 0, 0, 0, stall_v, "wait_mem_hold");
        drive(1, OP_JMP, 1, 0, 1, 0, 0, stall_v, "wait_mem_ready_cycle");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "mem_resume");

`ifdef FETCH_CTRL_HALT_EN
        drive(1, OP_HALT, 1, 0, 1, 0, 0, brdec_v, "halt_decode");
        for (int i = 0; i < 10; i++)
            drive(1, OP_JMP, 1, 1, 0, 0, 0, e(0, 0, 0, 1, 0, 1, 0), "halt_hold");
        drive(0, NOP, 0, 0, 1, 0, 0, rst_v, "halt_reset");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "run_after_halt_reset");
`else
        drive(1, OP_HALT, 1, 0, 1, 0, 0, def_v, "halt_is_sequential");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "after_halt_opcode");
`endif

        drive(1, OP_BNE, 1, 0, 1, 0, 0, brdec_v, "bne_timeout_decode");
        for (int i = 0; i < 7; i++)
            drive(1, OP_JMP, 1, 1, 0, 0, 1, stall_v, "br_wait_ignores_stalls");
        drive(1, NOP, 0, 0, 1, 0, 0, e(0, 1, 0, 0, 0, 0, 0), "timeout_fires");
        drive(1, NOP, 0, 0, 1, 0, 0, e(0, 1, 1, 0, 0, 0, 1), "timeout_flag_set");
        drive(1, OP_BEQ, 1, 0, 1, 0, 0, e(0, 0, 1, 1, 0, 0, 1), "beq_decode_sticky");
        drive(1, NOP, 0, 0, 1, 1, 1, e(3, 1, 0, 0, 0, 0, 1), "beq_taken_sticky");
        drive(1, NOP, 0, 0, 1, 0, 0, e(0, 1, 1, 0, 0, 0, 1), "timeout_still_sticky");
        drive(0, NOP, 0, 0, 1, 0, 0, rst_v, "reset_clears_timeout");
        drive(1, NOP, 0, 0, 1, 0, 0, def_v, "run_after_reset");

        drive(1, OP_BEQ, 1, 0, 1, 0, 0, brdec_v, "beq_decode_2");
        drive(1, NOP, 0, 0, 1, 0, 0, stall_v, "beq_wait_2");
        drive(0, NOP, 0, 0, 1, 1, 1, rst_v, "reset_mid_br_wait");
        drive(1, OP_JMP, 1, 0, 1, 0, 0, e(1, 1, 1, 1, 0, 0, 0), "jmp_after_abandon");
        drive(1, NOP, 0, 0, 1, 1, 1, def_v, "run_ignores_stale_branch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, rising-edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: id_opcode  in  5  opcode of instruction in fetch/decode register.
REQ-004 SHALL have port: id_valid  in  1  id_opcode is meaningful this cycle.
REQ-005 SHALL have port: ex_branch_valid  in  1  branch outcome from execute is valid this cycle.
REQ-006 SHALL have port: ex_branch_taken  in  1  resolved branch is taken; qualified by ex_branch_valid.
REQ-007 SHALL have port: hazard_load_use  in  1  decode depends on load now in execute.
REQ-008 SHALL have port: imem_ready  in  1  instruction memory returns data this cycle.
REQ-009 SHALL have port: NextInstrSel  out  2  fetch mux select: 00 pc+4, 01 jump Address, 10 Rs, 11 Branch.
REQ-010 SHALL have port: pc_en  out  1  PC register write enable.
REQ-011 SHALL have port: ifid_en  out  1  fetch register load enable.
REQ-012 SHALL have port: ifid_flush  out  1  fetch register cleared to NOP next edge.
REQ-013 SHALL have port: idex_bubble  out  1  insert NOP into decode/execute register.
REQ-014 SHALL have port: halted  out  1  core halted.
REQ-015 SHALL have port: br_timeout  out  1  sticky: branch outcome never arrived.

Function
REQ-016 SHALL implement FSM states RUN, WAIT_MEM, BR_WAIT, HALT; registered state, combinational outputs.
REQ-017 RUN default SHALL be NextInstrSel=00, pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-018 RUN priority SHALL be: imem_ready=0 > hazard_load_use > control transfer in ID > default.
REQ-019 RUN with imem_ready=0 SHALL drive pc_en=0, ifid_en=0 and go to WAIT_MEM; WAIT_MEM holds same outputs, returns to RUN in the cycle after imem_ready=1.
REQ-020 RUN with hazard_load_use=1 SHALL drive pc_en=0, ifid_en=0, idex_bubble=1 for each asserted cycle; no control transfer decoded that cycle.
REQ-021 RUN, id_valid=1, OP_JMP SHALL drive NextInstrSel=01, ifid_flush=1 in that cycle; stay RUN.
REQ-022 RUN, id_valid=1, OP_JR SHALL drive NextInstrSel=10, ifid_flush=1; stay RUN.
REQ-023 RUN, id_valid=1, OP_BEQ/OP_BNE SHALL drive pc_en=0, ifid_flush=1, clear timeout counter, go to BR_WAIT.
REQ-024 BR_WAIT SHALL drive pc_en=0, ifid_en=0 until ex_branch_valid=1; then taken: NextInstrSel=11, pc_en=1; not taken: NextInstrSel=00, pc_en=1; next state RUN.
REQ-025 BR_WAIT SHALL count cycles in a 3-bit counter; at count 7 with no ex_branch_valid, SHALL treat as not taken, set br_timeout, go to RUN.
REQ-026 br_timeout SHALL remain 1 until reset.
REQ-027 imem_ready and hazard_load_use SHALL be ignored in BR_WAIT and HALT.
REQ-028 id_valid=0 SHALL suppress all opcode decoding.

Reset
REQ-029 While rst=0: state RUN, counter 0, NextInstrSel=00, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=0, halted=0, br_timeout=0.
REQ-030 Reset mid-BR_WAIT or mid-HALT SHALL abandon the operation; first cycle after rst rises follows RUN rules.

Configuration
REQ-031 Macro FETCH_CTRL_HALT_EN defined: RUN with id_valid=1, OP_HALT SHALL drive pc_en=0, ifid_flush=1, go to HALT; HALT holds pc_en=0, ifid_en=0, ifid_flush=1, halted=1 until reset.
REQ-032 Macro undefined: OP_HALT SHALL be sequential fetch (00); HALT state unreachable; halted tied 0.

Structure
REQ-033 Package fetch_pkg SHALL hold opcode constants (OP_JMP=5'b10000, OP_JR=5'b10001, OP_BEQ=5'b10010, OP_BNE=5'b10011, OP_HALT=5'b11111), NextInstrSel encodings, and the FSM state enum.
REQ-034 Sub-module fetch_br_timer (3-bit clear/enable counter, terminal flag) SHALL implement the timeout count.

Verification
REQ-035 Release reset, id_valid=0, imem_ready=1 -> NextInstrSel=00, pc_en=1 every cycle; all flags 0.
REQ-036 OP_JMP with id_valid=1 -> same cycle NextInstrSel=01, ifid_flush=1; next cycle default.
REQ-037 OP_BEQ, ex_branch_valid=1 and taken=1 two cycles later -> pc_en=0 for two cycles, then NextInstrSel=11, pc_en=1, then RUN.
REQ-038 OP_BNE, no ex_branch_valid for 8 cycles -> br_timeout=1, NextInstrSel=00, back in RUN; stays 1 until rst=0.
REQ-039 hazard_load_use=1 and OP_JR together, imem_ready=1 -> idex_bubble=1, pc_en=0, NextInstrSel=00; OP_JR honoured next cycle.
REQ-040 With FETCH_CTRL_HALT_EN, OP_HALT -> halted=1, pc_en=0 held 10 cycles; rst=0 then 1 -> halted=0, RUN.
